// File: rtl/mem_port_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single memory port
// with a fixed read latency of MEM_LATENCY cycles.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic       GRANT_I = 1'b0;
    localparam logic       GRANT_D = 1'b1;
    localparam logic [3:0] LAT     = 4'(MEM_LATENCY);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_any;
    logic        w_grant_d;
    logic        w_rdata_done;

    // A tie goes to whichever side was not served last.
    assign w_grant_any  = i_req | d_req;
    assign w_grant_d    = d_req & (~i_req | (r_last_grant == GRANT_I));
    assign w_rdata_done = (r_state == S_WAIT) && (r_cnt == 4'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: the default assignment before the case keeps this purely
    // combinational; a missing branch would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en = (r_state == S_ISSUE);
        mem_we = (r_state == S_ISSUE) & r_we;
        i_ack  = (r_state == S_ACK) & (r_last_grant == GRANT_I);
        d_ack  = (r_state == S_ACK) & (r_last_grant == GRANT_D);
        busy   = (r_state != S_IDLE);
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

    // Request fields are captured at grant so the requester may change or drop
    // them afterwards; r_last_grant doubles as the owner of the current transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_last_grant <= GRANT_D;
            r_addr       <= 32'd0;
            r_we         <= 1'b0;
            r_wdata      <= 32'd0;
            r_i_rdata    <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_last_grant <= w_grant_d;
                        r_addr       <= w_grant_d ? d_addr : i_addr;
                        r_we         <= w_grant_d & d_we;
                        if (w_grant_d) r_wdata <= d_wdata;
                    end
                end
                S_ISSUE: r_cnt <= LAT;
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_rdata_done && !r_we) begin
                        if (r_last_grant == GRANT_I) r_i_rdata <= mem_rdata;
                        else                         r_d_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at latency 1, one at latency 4,
// each fed by a memory model whose read data is valid only in the exact latency cycle.
module tb_mem_port_arbiter;

    localparam logic [31:0] KEY = 32'hE3A00101;
    localparam logic [31:0] BAD = 32'hBAD0BAD0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // latency-1 instance
    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // latency-4 instance
    logic        i_req4 = 0, d_req4 = 0, d_we4 = 0;
    logic [31:0] i_addr4 = 0, d_addr4 = 0, d_wdata4 = 0;
    logic        i_ack4, d_ack4, mem_en4, mem_we4, busy4;
    logic [31:0] i_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;

    mem_port_arbiter #(.MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req4), .i_addr(i_addr4), .i_ack(i_ack4), .i_rdata(i_rdata4),
        .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
        .d_ack(d_ack4), .d_rdata(d_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_rdata(mem_rdata4), .busy(busy4)
    );

    // Memory models: data = addr ^ KEY, driven only in the cycle the DUT must sample.
    logic        en1_d;
    logic [31:0] addr1_d;
    logic [3:0]  en4_p;
    logic [31:0] addr4_p [4];

    always @(posedge clk) begin
        en1_d   <= mem_en;
        addr1_d <= mem_addr;
        en4_p   <= {en4_p[2:0], mem_en4};
        addr4_p[0] <= mem_addr4;
        for (int k = 1; k < 4; k++) addr4_p[k] <= addr4_p[k-1];
    end

    assign mem_rdata  = en1_d    ? (addr1_d ^ KEY)    : BAD;
    assign mem_rdata4 = en4_p[3] ? (addr4_p[3] ^ KEY) : BAD;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i_ack"},   {31'd0, i_ack},  32'd0);
        check({tag, "_d_ack"},   {31'd0, d_ack},  32'd0);
        check({tag, "_mem_en"},  {31'd0, mem_en}, 32'd0);
        check({tag, "_mem_we"},  {31'd0, mem_we}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy},   32'd0);
        check({tag, "_addr"},    mem_addr,        32'd0);
        check({tag, "_wdata"},   mem_wdata,       32'd0);
        check({tag, "_i_rdata"}, i_rdata,         32'd0);
        check({tag, "_d_rdata"}, d_rdata,         32'd0);
    endtask

    initial begin
        int n_ack;
        int last_cyc;
        int cyc;
        bit found;

        // Reset state
        #2;
        check_zero("rst0");
        check("rst0_busy4", {31'd0, busy4}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single instruction read, latency 1
        i_req = 1; i_addr = 32'h100;
        tick();
        check("rd_c1_en",   {31'd0, mem_en}, 32'd1);
        check("rd_c1_addr", mem_addr, 32'h100);
        check("rd_c1_we",   {31'd0, mem_we}, 32'd0);
        check("rd_c1_ack",  {31'd0, i_ack}, 32'd0);
        tick();
        check("rd_c2_en",   {31'd0, mem_en}, 32'd0);
        check("rd_c2_ack",  {31'd0, i_ack}, 32'd0);
        tick();
        check("rd_c3_ack",  {31'd0, i_ack}, 32'd1);
        check("rd_c3_data", i_rdata, 32'hE3A00001);
        check("rd_c3_dack", {31'd0, d_ack}, 32'd0);
        i_req = 0;
        tick();
        check("rd_c4_ack",  {31'd0, i_ack}, 32'd0);
        check("rd_c4_busy", {31'd0, busy}, 32'd0);
        check("rd_c4_hold", mem_addr, 32'h100);
        check("rd_c4_data", i_rdata, 32'hE3A00001);

        // Tie after reset, then sustained contention
        rst_n = 0;
        #1;
        check_zero("rst1");
        tick();
        rst_n = 1;
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_addr = 32'h400; d_we = 0;
        n_ack = 0; last_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (i_ack || d_ack) begin
                check("rr_onehot", {31'd0, i_ack & d_ack}, 32'd0);
                check("rr_order", {31'd0, d_ack}, {31'd0, n_ack[0]});
                if (n_ack[0]) check("rr_d_data", d_rdata, 32'hE3A00501);
                else          check("rr_i_data", i_rdata, 32'hE3A00201);
                if (n_ack == 0) check("rr_first", c, 3);
                else            check("rr_spacing", c - last_cyc, 4);
                last_cyc = c;
                n_ack++;
                if (n_ack == 6) begin
                    i_req = 0; d_req = 0;
                    break;
                end
            end
        end
        check("rr_count", n_ack, 6);

        // Data write with inputs changed/dropped after grant; a short i_req pulse
        // while busy must be ignored
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        tick();
        check("wr_en",    {31'd0, mem_en}, 32'd1);
        check("wr_we",    {31'd0, mem_we}, 32'd1);
        check("wr_addr",  mem_addr,  32'h200);
        check("wr_wdata", mem_wdata, 32'hDEADBEEF);
        d_req = 0; d_we = 0; d_addr = 32'hFFF0; d_wdata = 32'h12345678;
        #1;
        check("wr_latch_addr",  mem_addr,  32'h200);
        check("wr_latch_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        check("wr_c2_en",   {31'd0, mem_en}, 32'd0);
        check("wr_c2_we",   {31'd0, mem_we}, 32'd0);
        check("wr_c2_hold", mem_addr, 32'h200);
        i_req = 1; i_addr = 32'h900;
        tick();
        check("wr_ack",   {31'd0, d_ack}, 32'd1);
        check("wr_iack",  {31'd0, i_ack}, 32'd0);
        check("wr_rdata", d_rdata, 32'hE3A00501);
        i_req = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("drop_busy", {31'd0, busy}, 32'd0);
            check("drop_en",   {31'd0, mem_en}, 32'd0);
        end

        // Reset in WAIT; last_grant must return to D so I wins the next tie
        i_req = 1; i_addr = 32'h600;
        tick();
        tick();
        check("rw_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 0;
        #1;
        check_zero("rst2");
        d_req = 1; d_addr = 32'h700; d_we = 0;
        tick();
        check("rst2_noack", {31'd0, i_ack | d_ack}, 32'd0);
        rst_n = 1;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (i_ack || d_ack) begin
                check("rst2_first_i", {31'd0, i_ack}, 32'd1);
                check("rst2_lat",     c, 3);
                check("rst2_i_data",  i_rdata, 32'hE3A00701);
                found = 1;
                break;
            end
        end
        check("rst2_i_seen", {31'd0, found}, 32'd1);
        i_req = 0;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (i_ack || d_ack) begin
                check("rst2_then_d", {31'd0, d_ack}, 32'd1);
                check("rst2_d_data", d_rdata, 32'hE3A00601);
                found = 1;
                break;
            end
        end
        check("rst2_d_seen", {31'd0, found}, 32'd1);
        d_req = 0;

        // Latency 4 instance
        i_req4 = 1; i_addr4 = 32'h500;
        found = 0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            cyc = c;
            if (c == 1) begin
                check("l4_en",   {31'd0, mem_en4}, 32'd1);
                check("l4_addr", mem_addr4, 32'h500);
            end else begin
                check("l4_en_once", {31'd0, mem_en4}, 32'd0);
            end
            if (i_ack4) begin
                found = 1;
                i_req4 = 0;
                break;
            end
        end
        check("l4_seen", {31'd0, found}, 32'd1);
        check("l4_lat",  cyc, 6);
        check("l4_data", i_rdata4, 32'hE3A00401);
        tick();
        check("l4_idle", {31'd0, busy4}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning the memory read latency in cycles; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_req  input  1  instruction-side request; held high until i_ack.
REQ-005 SHALL have port i_addr  input  32  instruction read address.
REQ-006 SHALL have port i_ack  output  1  one-cycle completion pulse to the instruction side.
REQ-007 SHALL have port i_rdata  output  32  instruction read data; valid while i_ack is high, held until the next i_ack.
REQ-008 SHALL have port d_req  input  1  data-side request; held high until d_ack.
REQ-009 SHALL have port d_we  input  1  data-side write enable (1 = write, 0 = read).
REQ-010 SHALL have port d_addr  input  32  data-side address.
REQ-011 SHALL have port d_wdata  input  32  data-side write data.
REQ-012 SHALL have port d_ack  output  1  one-cycle completion pulse to the data side.
REQ-013 SHALL have port d_rdata  output  32  data read data; valid while d_ack is high, held until the next data-read d_ack.
REQ-014 SHALL have port mem_en  output  1  memory access strobe.
REQ-015 SHALL have port mem_we  output  1  memory write enable; qualified by mem_en.
REQ-016 SHALL have port mem_addr  output  32  memory address.
REQ-017 SHALL have port mem_wdata  output  32  memory write data.
REQ-018 SHALL have port mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after the mem_en cycle.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and ACK, with a 4-bit latency counter and a last_grant bit (I or D).
REQ-021 In IDLE with exactly one request high, the arbiter SHALL grant that requester and go to ISSUE.
REQ-022 In IDLE with both requests high, the arbiter SHALL grant the requester that is not last_grant (round-robin), then update last_grant.
REQ-023 On grant, the arbiter SHALL latch the address, we and wdata; inputs changing after grant SHALL have no effect on the transaction.
REQ-024 In ISSUE, the arbiter SHALL drive mem_en=1 for exactly one cycle with the latched mem_addr, mem_we and mem_wdata (mem_we=0 for instruction grants), load the counter with MEM_LATENCY, and go to WAIT.
REQ-025 In WAIT, the arbiter SHALL decrement the counter each cycle; when the counter reaches 1, it SHALL sample mem_rdata at that edge into the granted port's rdata register (reads only) and go to ACK.
REQ-026 In ACK, the arbiter SHALL drive the granted port's ack high for one cycle, perform no arbitration, and return to IDLE.
REQ-027 Latency SHALL be as follows: with a request first sampled at edge N, mem_en SHALL be high in cycle N+1, and ack SHALL be high in cycle N+MEM_LATENCY+2.
REQ-028 For a write, the ack timing SHALL match a read, and d_rdata SHALL be unchanged.
REQ-029 At most one ack SHALL be high in any cycle, and mem_en SHALL never be high outside ISSUE.
REQ-030 A request dropped after grant SHALL still complete with its ack; a request dropped before grant SHALL be ignored.
REQ-031 Outside ISSUE, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-032 Throughput SHALL be at most one transaction per MEM_LATENCY+3 cycles.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, last_grant=D, counter=0, all acks=0, mem_en=0, mem_we=0, busy=0, and mem_addr, mem_wdata, i_rdata and d_rdata all to 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no ack; after release, pending requests SHALL be arbitrated afresh from IDLE.

Verification
REQ-035 Single read: with MEM_LATENCY=1, assert i_req with i_addr=0x100 at edge 0 and return memory data 0xE3A00001 -> mem_en and mem_addr=0x100 in cycle 1, i_ack with i_rdata=0xE3A00001 in cycle 3.
REQ-036 Tie after reset: assert i_req and d_req simultaneously -> instruction granted first, data granted on the next IDLE, one ack each, never overlapping.
REQ-037 Sustained contention: hold both requests for 6 transactions -> grants alternate I, D, I, D, I, D.
REQ-038 Data write: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> one mem_en cycle with mem_we=1 and those values, d_ack at the read-equivalent time, d_rdata unchanged.
REQ-039 MEM_LATENCY=4 -> ack 6 cycles after the request is sampled, and mem_rdata sampled exactly 4 cycles after the mem_en cycle.
REQ-040 Reset in WAIT: pulse rst_n low -> no ack, all outputs zero, then a re-held i_req completes normally with instruction priority.
